// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] PC_INCR           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a fetched instruction that cannot enter the output register.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  // Push wins over pop so a simultaneous drain and refill keeps the slot occupied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem FSM, output register and skid buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_if.master     imem,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         req_valid_q, req_valid_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  instr_q, instr_d;

  logic         buf_valid, buf_valid_d;
  logic         buf_flush, buf_push, buf_pop;
  fetch_entry_t buf_entry, rsp_entry;

  logic req_fire, consume, rsp_load, out_free;

  assign req_fire  = req_valid_q & imem.imem_req_ready;
  assign consume   = valid_q & ~stall_in;
  assign out_free  = ~valid_q | consume;
  assign rsp_entry = '{pc: req_pc_q, instr: imem.imem_rsp_data};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    valid_d   = valid_q;
    pc_out_d  = pc_out_q;
    instr_d   = instr_q;
    buf_flush = 1'b0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    rsp_load  = 1'b0;

    if (redirect_valid) begin
      pc_d      = align_word(redirect_pc);
      valid_d   = 1'b0;
      instr_d   = NOP_INSTR;
      buf_flush = 1'b1;
      unique case (state_q)
        ST_REQ:   state_d = req_fire ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = imem.imem_rsp_valid ? ST_REQ : ST_DRAIN;
        ST_DRAIN: state_d = imem.imem_rsp_valid ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (req_fire) begin
            pc_d     = pc_q + PC_INCR;
            req_pc_d = pc_q;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.imem_rsp_valid) begin
            rsp_load = 1'b1;
            state_d  = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem.imem_rsp_valid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase

      // Buffered entry is older than any arriving response, so it drains first.
      if (out_free) begin
        if (buf_valid) begin
          valid_d  = 1'b1;
          pc_out_d = buf_entry.pc;
          instr_d  = buf_entry.instr;
          buf_pop  = 1'b1;
          buf_push = rsp_load;
        end else if (rsp_load) begin
          valid_d  = 1'b1;
          pc_out_d = rsp_entry.pc;
          instr_d  = rsp_entry.instr;
        end else if (consume) begin
          valid_d  = 1'b0;
          instr_d  = NOP_INSTR;
        end
      end else if (rsp_load) begin
        buf_push = 1'b1;
      end
    end

    if (buf_flush)     buf_valid_d = 1'b0;
    else if (buf_push) buf_valid_d = 1'b1;
    else if (buf_pop)  buf_valid_d = 1'b0;
    else               buf_valid_d = buf_valid;

    req_valid_d = (state_d == ST_REQ) & ~buf_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      valid_q     <= 1'b0;
      pc_out_q    <= '0;
      instr_q     <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      valid_q     <= valid_d;
      pc_out_q    <= pc_out_d;
      instr_q     <= instr_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (buf_flush),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .entry_i (rsp_entry),
    .valid_o (buf_valid),
    .entry_o (buf_entry)
  );

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_req_addr  = pc_q;
  assign pc_out              = pc_out_q;
  assign instruction_out     = instr_q;
  assign valid_out           = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem            (bus.master),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    check({tag, ".pc"},    pc_out, pc);
    check({tag, ".instr"}, instruction_out, ins);
  endtask

  task automatic check_req(input string tag, input logic v, input logic [31:0] addr);
    check({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, {31'd0, v});
    if (v) check({tag, ".req_addr"}, bus.imem_req_addr, addr);
  endtask

  initial begin
    reset              = 1'b0;
    stall_in           = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    step(); step();

    // Reset values
    check_out("rst", 1'b0, 32'h0, NOP);
    check_req("rst", 1'b0, 32'h0);
    check("rst.addr", bus.imem_req_addr, 32'h0);

    // First fetch after reset release
    bus.imem_req_ready = 1'b1;
    reset = 1'b1;
    step();
    check_req("boot", 1'b1, 32'h0);
    step();
    check_req("boot_wait", 1'b0, 32'h0);
    check_out("boot_wait", 1'b0, 32'h0, NOP);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hAAAA_0001;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_out("first", 1'b1, 32'h0, 32'hAAAA_0001);
    check_req("first", 1'b1, 32'h4);

    // Three stalled cycles with a response landing in the skid buffer
    stall_in = 1'b1;
    step();
    check_out("stall1", 1'b1, 32'h0, 32'hAAAA_0001);
    check_req("stall1", 1'b0, 32'h0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBBBB_0002;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_out("stall2", 1'b1, 32'h0, 32'hAAAA_0001);
    check_req("stall2", 1'b0, 32'h0);
    step();
    check_out("stall3", 1'b1, 32'h0, 32'hAAAA_0001);
    check_req("stall3", 1'b0, 32'h0);
    stall_in = 1'b0;
    step();
    check_out("unstall", 1'b1, 32'h4, 32'hBBBB_0002);
    check_req("unstall", 1'b1, 32'h8);
    step();
    check_out("drained", 1'b0, 32'h4, NOP);
    check_req("drained", 1'b0, 32'h0);

    // Redirect while a response is outstanding -> DRAIN
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2003;
    step();
    redirect_valid = 1'b0;
    check_req("drain", 1'b0, 32'h0);
    check("drain.valid", {31'd0, valid_out}, 32'd0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_0003;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("dropped.valid", {31'd0, valid_out}, 32'd0);
    check_req("redir_req", 1'b1, 32'h0000_2000);
    step();
    check("redir_wait.valid", {31'd0, valid_out}, 32'd0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hCCCC_0004;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_out("redir_rsp", 1'b1, 32'h0000_2000, 32'hCCCC_0004);
    check_req("redir_rsp", 1'b1, 32'h0000_2004);

    // Redirect coincident with a response in WAIT -> no DRAIN
    step();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hEEEE_0005;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    step();
    bus.imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    check("coinc.valid", {31'd0, valid_out}, 32'd0);
    check_req("coinc", 1'b1, 32'h0000_3000);
    step();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1111_0006;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_out("coinc_rsp", 1'b1, 32'h0000_3000, 32'h1111_0006);

    // Address held while memory is not ready
    bus.imem_req_ready = 1'b0;
    step();
    check_req("hold1", 1'b1, 32'h0000_3004);
    step();
    check_req("hold2", 1'b1, 32'h0000_3004);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    check_req("top", 1'b1, 32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h2222_0007;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'h2222_0007);
    check_req("wrap", 1'b1, 32'h0000_0000);

    // Reset asserted with a response outstanding
    bus.imem_req_ready = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_out("midrst", 1'b0, 32'h0, NOP);
    check_req("midrst", 1'b0, 32'h0);
    step();
    step();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h9999_0008;
    reset = 1'b1;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_out("rst_rel", 1'b0, 32'h0, NOP);
    check_req("rst_rel", 1'b1, 32'h0);
    step();
    check("rst_stale.valid", {31'd0, valid_out}, 32'd0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h3333_0009;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_out("rst_fetch", 1'b1, 32'h0, 32'h3333_0009);

    // Redirect on the cycle the request is accepted -> DRAIN
    redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
    step();
    redirect_valid = 1'b0;
    check("acc_redir.valid", {31'd0, valid_out}, 32'd0);
    check_req("acc_redir", 1'b0, 32'h0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h4444_000A;
    step();
    bus.imem_rsp_valid = 1'b0;
    check("acc_drop.valid", {31'd0, valid_out}, 32'd0);
    check_req("acc_drop", 1'b1, 32'h0000_5000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be driven on instruction_out whenever valid_out=0.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  reset SHALL be asynchronous and active-low (0 = reset).
REQ-005 stall_in  in  1  downstream (IF/ID register) cannot accept this cycle.
REQ-006 redirect_valid  in  1  taken branch/jump: flush and refetch from redirect_pc.
REQ-007 redirect_pc  in  32  new fetch address.
REQ-008 imem_req_valid  out  1  instruction memory read request.
REQ-009 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-010 imem_req_addr  out  32  word-aligned fetch address.
REQ-011 imem_rsp_valid  in  1  read data valid; exactly one per accepted request, in order.
REQ-012 imem_rsp_data  in  32  instruction word.
REQ-013 pc_out  out  32  PC of the presented instruction.
REQ-014 instruction_out  out  32  presented instruction.
REQ-015 valid_out  out  1  pc_out/instruction_out hold a real instruction.

Function
REQ-016 States SHALL be REQ (request pending), WAIT (one accepted, response outstanding) and DRAIN (outstanding response to discard); at most one request SHALL be outstanding.
REQ-017 Output consumed = valid_out & ~stall_in; a one-entry skid buffer (buf_valid, buf_pc, buf_instr) SHALL hold a response that cannot enter the output register.
REQ-018 In REQ: imem_req_valid=~buf_valid, imem_req_addr=pc; on valid&ready: pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), go WAIT.
REQ-019 addr SHALL stay stable while valid & ~ready, except on redirect (request withdrawn; memory tolerates withdrawal).
REQ-020 In WAIT on imem_rsp_valid: load the output register if it is empty or consumed this cycle, else load the skid buffer; go REQ.
REQ-021 On consume with buf_valid=1, buffer contents SHALL move to the output register and buf_valid<=0, same cycle.
REQ-022 On consume with nothing to load, valid_out<=0 and instruction_out<=NOP_INSTR.
REQ-023 Fetch latency SHALL be one cycle from imem_rsp_valid to valid_out=1 (empty output path).
REQ-024 With stall_in=1, pc_out, instruction_out and valid_out SHALL hold.
REQ-025 Redirect is highest priority: pc<=redirect_pc with bits[1:0] forced to 0; valid_out<=0; buf_valid<=0; no response loaded.
REQ-026 Redirect next state: DRAIN if a response is still outstanding (WAIT without rsp, or REQ with req accepted the same cycle), else REQ.
REQ-027 In DRAIN: the next imem_rsp_valid SHALL be discarded, then go REQ; imem_req_valid=0; a further redirect SHALL update pc only.
REQ-028 Redirect in WAIT coincident with imem_rsp_valid: the response SHALL be discarded and the state SHALL go REQ.

Reset
REQ-029 While reset=0: state=REQ, pc=RESET_PC, valid_out=0, pc_out=0, instruction_out=NOP_INSTR, buf_valid=0, imem_req_valid=0.
REQ-030 imem_req_valid SHALL first assert in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-transaction SHALL abandon any outstanding response with no DRAIN after release.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the state encoding, NOP_INSTR default and PC increment constant (4).
REQ-033 The skid buffer SHALL be sub-module fetch_skid_buffer (32-bit pc + 32-bit instr, one entry); the FSM and PC register stay in fetch_unit.

Verification
REQ-034 Reset release, ready=1, rsp 1 cycle later with 32'hAAAA_0001 -> pc_out=0, instruction_out=32'hAAAA_0001, valid_out=1; next request addr 32'h4.
REQ-035 stall_in=1 for 3 cycles with output valid and one response arriving -> outputs hold, buffer fills, req_valid=0; on release the buffered instruction is presented next cycle, no loss or duplication.
REQ-036 Redirect to 32'h0000_2003 while in WAIT -> next rsp dropped (DRAIN), next req addr=32'h0000_2000, valid_out=0 until the new response.
REQ-037 Redirect coincident with rsp in WAIT -> response dropped, no DRAIN, req to redirect target the next cycle.
REQ-038 pc=32'hFFFF_FFFC accepted -> next req addr=32'h0000_0000.
REQ-039 reset=0 asserted in WAIT, released 2 cycles later -> outputs at reset values, req addr=RESET_PC, stale rsp (if any) not presented.
